// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC and issues one word read per
//   cycle to a synchronous instruction memory with 1-cycle read latency.
//   Returned words are buffered with their fetch address in a small FIFO that
//   feeds IF/ID through a valid/ready handshake. A credit check ensures that a
//   returning word always has a free slot. Taken branches and jumps squash the
//   buffer and the read in flight. A misaligned redirect halts fetch until the
//   next reset.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/_addr    read strobe and word-aligned byte address to imem
//   imem_rdata        read data, valid the cycle after imem_req
//   redirect_valid/pc branch/jump restart request and target
//   out_valid/ready   handshake towards IF/ID
//   out_instr/pc      instruction at the FIFO head and its fetch address
//   fetch_err         sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic            vld_p1;
    logic [31:0]     pc_p1;
    logic [31:0]     instr_q [FIFO_DEPTH];
    logic [31:0]     pc_q    [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     credit_used;
    logic [CW:0]     credit_limit;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // A word already buffered plus one in flight both hold a slot; a pop in
    // this cycle frees one, so the limit rises by one rather than the usage
    // dropping (keeps the arithmetic unsigned).
    assign credit_used  = {1'b0, count} + {{CW{1'b0}}, vld_p1};
    assign credit_limit = DEPTH_C + {{CW{1'b0}}, pop};

    assign issue = (state == RUN) & ~redirect_valid & rst_n
                 & (credit_used < credit_limit);

    assign imem_req  = issue;
    assign imem_addr = pc;

    // A returning word is dropped if a redirect squashes it or fetch is halted.
    assign push = vld_p1 & (state == RUN) & ~redirect_valid;

    assign out_instr = out_valid ? instr_q[rd_ptr] : 32'h0;
    assign out_pc    = out_valid ? pc_q[rd_ptr]    : 32'h0;

    // ---- control: FSM, fetch PC, in-flight flag, FIFO occupancy ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            fetch_err <= 1'b0;
            pc        <= RESET_PC;
            vld_p1    <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                pc <= pc + 32'd4;
            end

            if (state == HALT) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (redirect_valid) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                if (redirect_pc[1:0] != 2'b00) begin
                    state     <= HALT;
                    fetch_err <= 1'b1;
                end else begin
                    pc <= redirect_pc;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // ---- data: address of the read in flight, FIFO storage ----
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= pc;
        end
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= pc_p1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Directed bench for imem_fetch_ctrl (RESET_PC=0, FIFO_DEPTH=2). A behavioural
//   synchronous memory returns a fixed function of the address one cycle after
//   each request. Each bench cycle starts 2 time units after the rising edge;
//   inputs are driven there and outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_err;

    int n_checks;
    int n_errors;

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8BAD_F00D;
    endfunction

    // Synchronous memory; junk on cycles without a request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc_exp);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".pc"},    out_pc,    pc_exp);
        chk({tag, ".instr"}, out_instr, mem_word(pc_exp));
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr_exp);
        chk({tag, ".req"},  {31'b0, imem_req}, 32'd1);
        chk({tag, ".addr"}, imem_addr, addr_exp);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst.req",   {31'b0, imem_req},  32'd0);
        chk("rst.addr",  imem_addr,          32'h0);
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.instr", out_instr,          32'h0);
        chk("rst.pc",    out_pc,             32'h0);
        chk("rst.err",   {31'b0, fetch_err}, 32'd0);

        // Streaming with out_ready=1: one fetch and one output per cycle
        tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                tick();
                #1;
            end
            chk_fetch("stream", 32'(4 * k));
            if (k < 2) chk_empty("stream");
            else       chk_out("stream", 32'(4 * (k - 2)));
        end

        // Stall from fill: exactly two words buffered, fetch stops, head held
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        #1;
        chk_fetch("stall.c0", 32'h0);
        chk_empty("stall.c0");
        tick();
        #1;
        chk_fetch("stall.c1", 32'h4);
        chk_empty("stall.c1");
        for (int k = 2; k < 6; k++) begin
            tick();
            #1;
            chk("stall.req", {31'b0, imem_req}, 32'd0);
            chk_out("stall.hold", 32'h0);
        end
        // Release: drain in order and resume at the next pc
        tick();
        out_ready = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) begin
                tick();
                #1;
            end
            chk_fetch("drain", 32'(8 + 4 * j));
            chk_out("drain", 32'(4 * j));
        end

        // Redirect to 0x40 with a buffered word and a read in flight
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("redir.t.req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) begin
                tick();
                #1;
            end
            chk_fetch("redir", 32'(32'h40 + 4 * (j - 1)));
            if (j < 3) chk_empty("redir");
            else       chk_out("redir", 32'(32'h40 + 4 * (j - 3)));
        end

        // Redirect near the top of the address space: pc wraps to 0
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #1;
        chk("wrap.t.req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int j = 1; j <= 5; j++) begin
            if (j > 1) begin
                tick();
                #1;
            end
            tgt = 32'hFFFF_FFF8 + 32'(4 * (j - 1));
            chk_fetch("wrap", tgt);
            if (j < 3) chk_empty("wrap");
            else       chk_out("wrap", 32'hFFFF_FFF8 + 32'(4 * (j - 3)));
        end
        chk("wrap.zero", out_pc, 32'h0000_0000);

        // Asynchronous reset mid-stream, no clock edge needed
        rst_n = 1'b0;
        #1;
        chk("arst.req",   {31'b0, imem_req},  32'd0);
        chk("arst.addr",  imem_addr,          32'h0);
        chk("arst.valid", {31'b0, out_valid}, 32'd0);
        chk("arst.instr", out_instr,          32'h0);
        chk("arst.pc",    out_pc,             32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_fetch("arst.c0", 32'h0);
        chk_empty("arst.c0");
        tick();
        #1;
        chk_fetch("arst.c1", 32'h4);
        chk_empty("arst.c1");
        tick();
        #1;
        chk_out("arst.c2", 32'h0);

        // Misaligned redirect: halt with sticky error
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        #1;
        chk("mis.t.req", {31'b0, imem_req},  32'd0);
        chk("mis.t.err", {31'b0, fetch_err}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                tick();
                #1;
            end
            chk("mis.err", {31'b0, fetch_err}, 32'd1);
            chk("mis.req", {31'b0, imem_req},  32'd0);
            chk_empty("mis");
        end
        // An aligned redirect while halted is ignored
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        chk("halt.redir.req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                tick();
                #1;
            end
            chk("halt.req", {31'b0, imem_req},  32'd0);
            chk("halt.err", {31'b0, fetch_err}, 32'd1);
            chk_empty("halt");
        end
        // Only reset clears the error
        rst_n = 1'b0;
        #1;
        chk("clr.err", {31'b0, fetch_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_fetch("clr.c0", 32'h0);
        tick();
        #1;
        chk_fetch("clr.c1", 32'h4);
        tick();
        #1;
        chk_out("clr.c2", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
